// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-access stage: opcodes, canned instructions
// and the stage state encoding.
package cpu_pkg;

  localparam logic [4:0]  OP_NOP = 5'd0;
  localparam logic [4:0]  OP_ST  = 5'd12;
  localparam logic [4:0]  OP_LD  = 5'd13;
  localparam logic [4:0]  OP_HLT = 5'd15;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] HLT_INSTR = {OP_HLT, 27'b0};

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Only LD and ST touch data memory; LDUMP/SDUMP and the rest pass through.
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Loadable up-counter that flags when it reaches TIMEOUT-1, used to bound how
// long a data-memory request may wait for its acknowledge.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_terminal
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes EX results to WB and runs LD/ST through
// a req/ack handshake, stalling upstream while a transaction is in flight.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       IR3,
  input  logic [15:0]       Z3,
  input  logic [15:0]       B3,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [31:0]       IR4,
  output logic [15:0]       Z4,
  output logic [15:0]       data_out,
  output logic              mem_err
);

  state_t      r_state;
  logic [31:0] r_hold_ir;
  logic [15:0] r_hold_z;
  logic [15:0] r_hold_b;
  logic [31:0] r_ir4;
  logic [15:0] r_z4;
  logic [15:0] r_data_out;
  logic        r_mem_err;

  logic w_in_req;
  logic w_is_mem;
  logic w_ctr_load;
  logic w_ctr_en;
  logic w_terminal;

  assign w_in_req   = (r_state == REQ);
  assign w_is_mem   = is_mem_op(IR3[31:27]);
  assign w_ctr_load = !w_in_req && !flush && w_is_mem;
  assign w_ctr_en   = w_in_req && !flush && !mem_ack && !w_terminal;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk        (clk),
    .rst_n      (clr),
    .i_load     (w_ctr_load),
    .i_en       (w_ctr_en),
    .o_terminal (w_terminal)
  );

  // Bus outputs are forced to zero outside REQ so nothing stale leaks out.
  assign stall     = w_in_req;
  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req && (r_hold_ir[31:27] == OP_ST);
  assign mem_addr  = w_in_req ? r_hold_z[ADDR_W-1:0] : '0;
  assign mem_wdata = w_in_req ? r_hold_b : '0;

  assign IR4      = r_ir4;
  assign Z4       = r_z4;
  assign data_out = r_data_out;
  assign mem_err  = r_mem_err;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= IDLE;
      r_hold_ir  <= '0;
      r_hold_z   <= '0;
      r_hold_b   <= '0;
      r_ir4      <= NOP_INSTR;
      r_z4       <= '0;
      r_data_out <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_ir4 <= NOP_INSTR;
            r_z4  <= '0;
          end else if (w_is_mem) begin
            r_hold_ir <= IR3;
            r_hold_z  <= Z3;
            r_hold_b  <= B3;
            r_ir4     <= NOP_INSTR;
            r_state   <= REQ;
          end else begin
            r_ir4 <= IR3;
            r_z4  <= Z3;
          end
        end
        REQ: begin
          // A flush withdraws the request even if the ack arrives this cycle.
          if (flush) begin
            r_ir4   <= NOP_INSTR;
            r_state <= IDLE;
          end else if (mem_ack) begin
            r_ir4 <= r_hold_ir;
            r_z4  <= r_hold_z;
            if (r_hold_ir[31:27] == OP_LD) begin
              r_data_out <= mem_rdata;
            end
            r_state <= IDLE;
          end else if (w_terminal) begin
            r_ir4     <= HLT_INSTR;
            r_mem_err <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_ir4 <= NOP_INSTR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, LD with wait states, ST/LD
// back-to-back, flush abort, timeout and asynchronous reset mid-access.
module tb_mem_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        clr;
  logic [31:0] IR3;
  logic [15:0] Z3;
  logic [15:0] B3;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [31:0] IR4;
  logic [15:0] Z4;
  logic [15:0] data_out;
  logic        mem_err;

  int vectors = 0;
  int errors  = 0;

  localparam logic [31:0] ADD_I  = {5'd2,  27'h0000123};
  localparam logic [31:0] LD_I   = {5'd13, 27'h0000045};
  localparam logic [31:0] ST_I   = {5'd12, 27'h0000067};
  localparam logic [31:0] LD2_I  = {5'd13, 27'h0000089};
  localparam logic [31:0] SUB_I  = {5'd3,  27'h00000AB};
  localparam logic [31:0] HALT_I = 32'h7800_0000;

  mem_stage #(
    .ADDR_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .IR3       (IR3),
    .Z3        (Z3),
    .B3        (B3),
    .flush     (flush),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .IR4       (IR4),
    .Z4        (Z4),
    .data_out  (data_out),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; IR3 = '0; Z3 = '0; B3 = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    vectors++; if (IR4 !== 32'h0) begin errors++; $display("FAIL reset_ir4: got %h want %h", IR4, 32'h0); end
    vectors++; if (Z4 !== 16'h0) begin errors++; $display("FAIL reset_z4: got %h want %h", Z4, 16'h0); end
    vectors++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h want %h", data_out, 16'h0); end
    vectors++; if ({mem_req, stall, mem_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {mem_req, stall, mem_err}); end
    tick();
    clr = 1'b1;
    $display("test_reset: reset state checked");
  endtask

  task automatic test_pass_through();
    IR3 = ADD_I; Z3 = 16'h1234;
    tick();
    vectors++; if (IR4 !== ADD_I) begin errors++; $display("FAIL pass_ir4: got %h want %h", IR4, ADD_I); end
    vectors++; if (Z4 !== 16'h1234) begin errors++; $display("FAIL pass_z4: got %h want %h", Z4, 16'h1234); end
    vectors++; if ({stall, mem_req} !== 2'b00) begin errors++; $display("FAIL pass_stall_req: got %b want 00", {stall, mem_req}); end
    $display("test_pass_through: ADD IR4=%h Z4=%h", IR4, Z4);
  endtask

  task automatic test_load_wait();
    IR3 = LD_I; Z3 = 16'h0040; B3 = 16'h0000;
    tick();
    IR3 = NOP_INSTR; Z3 = '0;
    for (int c = 0; c < 3; c++) begin
      vectors++; if ({mem_req, mem_we, stall} !== 3'b101) begin errors++; $display("FAIL ld_req_cyc%0d: got req/we/stall=%b want 101", c, {mem_req, mem_we, stall}); end
      vectors++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL ld_addr_cyc%0d: got %h want %h", c, mem_addr, 16'h0040); end
      vectors++; if (IR4 !== NOP_INSTR) begin errors++; $display("FAIL ld_ir4_bubble_cyc%0d: got %h want %h", c, IR4, NOP_INSTR); end
      if (c == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    vectors++; if (IR4 !== LD_I) begin errors++; $display("FAIL ld_ir4: got %h want %h", IR4, LD_I); end
    vectors++; if (Z4 !== 16'h0040) begin errors++; $display("FAIL ld_z4: got %h want %h", Z4, 16'h0040); end
    vectors++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL ld_data_out: got %h want %h", data_out, 16'hBEEF); end
    vectors++; if ({mem_req, stall} !== 2'b00) begin errors++; $display("FAIL ld_done_idle: got %b want 00", {mem_req, stall}); end
    $display("test_load_wait: LD addr=0040 data_out=%h", data_out);
  endtask

  task automatic test_back_to_back();
    IR3 = ST_I; Z3 = 16'h0010; B3 = 16'h00AA;
    tick();
    IR3 = LD2_I; Z3 = 16'h0020; B3 = 16'h0000;
    vectors++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL st_req_we: got %b want 11", {mem_req, mem_we}); end
    vectors++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL st_addr: got %h want %h", mem_addr, 16'h0010); end
    vectors++; if (mem_wdata !== 16'h00AA) begin errors++; $display("FAIL st_wdata: got %h want %h", mem_wdata, 16'h00AA); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    // IDLE cycle between the two transactions: LD is presented, not yet requested.
    vectors++; if (IR4 !== ST_I) begin errors++; $display("FAIL st_ir4: got %h want %h", IR4, ST_I); end
    vectors++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL st_data_out_kept: got %h want %h", data_out, 16'hBEEF); end
    vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_gap_req: got %b want 0", mem_req); end
    tick();
    IR3 = NOP_INSTR; Z3 = '0;
    vectors++; if ({mem_req, mem_we} !== 2'b10) begin errors++; $display("FAIL b2b_ld_req_we: got %b want 10", {mem_req, mem_we}); end
    vectors++; if (mem_addr !== 16'h0020) begin errors++; $display("FAIL b2b_ld_addr: got %h want %h", mem_addr, 16'h0020); end
    mem_ack = 1'b1; mem_rdata = 16'h1357;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    vectors++; if (IR4 !== LD2_I) begin errors++; $display("FAIL b2b_ld_ir4: got %h want %h", IR4, LD2_I); end
    vectors++; if (data_out !== 16'h1357) begin errors++; $display("FAIL b2b_ld_data: got %h want %h", data_out, 16'h1357); end
    $display("test_back_to_back: ST 0010<=00AA then LD 0020 data_out=%h", data_out);
  endtask

  task automatic test_flush();
    IR3 = ST_I; Z3 = 16'h0030; B3 = 16'h0055;
    tick();
    IR3 = NOP_INSTR; Z3 = '0; B3 = '0;
    vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_req_cyc1: got %b want 1", mem_req); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if ({mem_req, stall, mem_we} !== 3'b000) begin errors++; $display("FAIL flush_abort: got req/stall/we=%b want 000", {mem_req, stall, mem_we}); end
    vectors++; if (IR4 !== NOP_INSTR) begin errors++; $display("FAIL flush_ir4: got %h want %h", IR4, NOP_INSTR); end
    // A stray ack in IDLE must be ignored.
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    vectors++; if (data_out !== 16'h1357) begin errors++; $display("FAIL idle_ack_ignored: got %h want %h", data_out, 16'h1357); end
    vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_req: got %b want 0", mem_req); end
    IR3 = ADD_I; Z3 = 16'h7777; flush = 1'b1;
    tick();
    flush = 1'b0; IR3 = NOP_INSTR; Z3 = '0;
    vectors++; if ({IR4, Z4} !== {NOP_INSTR, 16'h0}) begin errors++; $display("FAIL idle_flush: got IR4=%h Z4=%h want 0/0", IR4, Z4); end
    $display("test_flush: ST aborted, IDLE flush squashed ADD");
  endtask

  task automatic test_timeout();
    IR3 = LD_I; Z3 = 16'h0050;
    tick();
    IR3 = NOP_INSTR; Z3 = '0;
    for (int c = 0; c < 4; c++) begin
      vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req_cyc%0d: got %b want 1", c, mem_req); end
      tick();
    end
    vectors++; if (IR4 !== HALT_I) begin errors++; $display("FAIL to_ir4: got %h want %h", IR4, HALT_I); end
    vectors++; if ({mem_err, mem_req} !== 2'b10) begin errors++; $display("FAIL to_err_req: got %b want 10", {mem_err, mem_req}); end
    IR3 = SUB_I; Z3 = 16'h4242;
    tick();
    IR3 = NOP_INSTR; Z3 = '0;
    vectors++; if (IR4 !== SUB_I) begin errors++; $display("FAIL to_after_ir4: got %h want %h", IR4, SUB_I); end
    vectors++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
    $display("test_timeout: LD 0050 timed out, IR4=%h mem_err=%b", HALT_I, mem_err);
  endtask

  task automatic test_reset_mid_access();
    IR3 = LD_I; Z3 = 16'h0060;
    tick();
    IR3 = NOP_INSTR; Z3 = '0;
    vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_req: got %b want 1", mem_req); end
    #2 clr = 1'b0;
    #1;
    vectors++; if ({mem_req, stall, mem_err} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b want 000", {mem_req, stall, mem_err}); end
    vectors++; if ({IR4, Z4, data_out} !== 64'h0) begin errors++; $display("FAIL rst_mid_regs: got IR4=%h Z4=%h data_out=%h want 0", IR4, Z4, data_out); end
    #1 clr = 1'b1;
    tick();
    vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_post_idle: got %b want 0", mem_req); end
    $display("test_reset_mid_access: async reset during REQ");
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_wait();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits between the EX stage and the write-back stage.
- Registers the EX result and the instruction register, and runs LD/ST data-memory transactions through a req/ack handshake.
- Stalls upstream while a transaction is in flight.
- Produces IR4, Z4 and data_out, which the write-back stage consumes.

Parameters:
- ADDR_W, 16, data-memory address width.
- TIMEOUT, 255, maximum cycles in REQ waiting for mem_ack before the access is aborted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-low reset.
- IR3  in  32  instruction register from EX; opcode in [31:27].
- Z3  in  16  EX result; the effective address for LD/ST.
- B3  in  16  store data for ST.
- flush  in  1  kill the younger instruction held in or entering this stage (WB loaded pc).
- stall  out  1  upstream must hold IR3/Z3/B3 this cycle.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write (ST), 0 = read (LD); valid while mem_req.
- mem_addr  out  ADDR_W  access address; valid while mem_req.
- mem_wdata  out  16  store data; valid while mem_req.
- mem_ack  in  1  memory completion; one-cycle pulse.
- mem_rdata  in  16  read data; valid with mem_ack.
- IR4  out  32  instruction register to WB.
- Z4  out  16  result to WB.
- data_out  out  16  loaded data to WB.
- mem_err  out  1  sticky flag: an access timed out.

Behaviour:
- Reset (clr low, asynchronous):
  - state = IDLE, timeout counter = 0.
  - IR4 = 32'h0 (NOP, opcode 0), Z4 = 0, data_out = 0.
  - Hold registers = 0, mem_req = 0, mem_err = 0.
- Opcodes: OP_LD = 5'd13, OP_ST = 5'd12, OP_HLT = 5'd15, OP_NOP = 5'd0. Every other opcode, including LDUMP/SDUMP, is non-memory.
- stall = (state == REQ), combinational.
- IDLE, per rising edge:
  - If flush: IR4 <= NOP, Z4 <= 0. Nothing is captured.
  - Else if IR3 opcode is LD or ST: capture IR3/Z3/B3 into hold regs, IR4 <= NOP (bubble), counter <= 0, next state REQ.
  - Else (pass-through): IR4 <= IR3, Z4 <= Z3, data_out holds its value. Latency is 1 cycle.
- REQ state:
  - Outputs: mem_req = 1, mem_we = (hold opcode == ST), mem_addr = hold Z[ADDR_W-1:0], mem_wdata = hold B.
  - IR4 remains NOP each cycle.
  - flush has priority over mem_ack: abort the access, IR4 <= NOP, state IDLE. mem_req drops the next cycle. The memory tolerates a request withdrawn before ack. A store aborted this way must not commit.
  - On mem_ack without flush:
    - IR4 <= hold IR, Z4 <= hold Z.
    - data_out <= mem_rdata for LD; data_out is unchanged for ST.
    - Next state IDLE.
  - Otherwise counter increments. When counter == TIMEOUT-1 and no ack arrives: IR4 <= {OP_HLT, 27'b0}, mem_err <= 1, next state IDLE. The access is dropped and WB halts.
- Outside REQ: mem_req = 0; mem_we, mem_addr and mem_wdata drive 0.
- Latency:
  - Non-memory instruction: 1 cycle.
  - LD/ST: 2 + (cycles before ack) cycles. With ack in the first REQ cycle, IR4 is valid 2 edges after capture.
- Back-to-back LD/ST: the second one is accepted in the IDLE cycle following the ack edge. At most one transaction is outstanding.
- mem_err clears only on reset.
- An ack seen in IDLE is ignored.

Decomposition:
- Package cpu_pkg: opcode constants (OP_NOP, OP_LD, OP_ST, OP_HLT), NOP_INSTR = 32'h0, state enum {IDLE, REQ}.
- Sub-module mem_timeout_ctr: loadable up-counter with terminal flag, parameterised by TIMEOUT.
- Everything else stays in mem_stage.

Test Plan:
- Pass-through: IR3 = ADD (opcode 2) with Z3 = 16'h1234 → next edge IR4 = IR3, Z4 = 16'h1234, stall = 0, mem_req never set.
- Load with wait states: IR3 = LD, Z3 = 16'h0040, ack after 3 REQ cycles with mem_rdata = 16'hBEEF →
  - mem_req = 1, mem_we = 0 and mem_addr = 16'h0040 for 3 cycles.
  - stall = 1 for those 3 cycles.
  - IR4 = NOP during REQ; then IR4 = LD, Z4 = 16'h0040, data_out = 16'hBEEF.
- Store then load back-to-back: ST with addr 16'h0010 and B3 = 16'h00AA, immediate ack, followed by LD → mem_we = 1 with mem_wdata = 16'h00AA; second request starts exactly 2 cycles after the first ack; data_out is unchanged by the ST.
- Flush mid-access: flush asserted in the second REQ cycle of an ST → mem_req drops the next cycle, IR4 = NOP, state IDLE, no ack is expected or used.
- Timeout: TIMEOUT = 4 with no ack → after 4 REQ cycles IR4 = {OP_HLT, 27'b0}, mem_err = 1, and mem_err stays 1 through further instructions.
- Reset mid-access: drive clr low while in REQ → immediately mem_req = 0, stall = 0, IR4 = 0, Z4 = 0, data_out = 0, mem_err = 0.
